// File: rtl/lv1_delay_multi.sv
// lv1_delay_multi: per-channel first-lv1 delay meter on a shared live-window tick counter.
// Define LV1_DELAY_CNT_EN to add per-channel lv1 rising-edge counters on output lv1_cnt.
module lv1_delay_multi #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 10,
  parameter int CNT_MAX = 1022
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 live,
  input  logic                 ena_delta,
  input  logic [NCH-1:0]       lv1,
  output logic [NCH*CNT_W-1:0] delay,
  output logic [NCH-1:0]       valid,
  output logic [NCH-1:0]       sat,
  output logic                 all_done,
  output logic [1:0]           state
`ifdef LV1_DELAY_CNT_EN
  ,
  output logic [NCH*16-1:0]    lv1_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(CNT_MAX);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pre_live_q, pre_live_d;
  logic [NCH*CNT_W-1:0] delay_q, delay_d;
  logic [NCH-1:0]       valid_q, valid_d;
  logic [NCH-1:0]       sat_q, sat_d;
  logic                 all_done_q, all_done_d;

  logic                 live_rise;
  logic [NCH-1:0]       valid_base;
  logic [NCH-1:0]       cap;
  logic [CNT_W-1:0]     cap_val;
  logic                 all_now;

  // Live edge detect and per-channel capture qualification
  always_comb begin
    live_rise  = live & ~pre_live_q;
    pre_live_d = live;
    // a rising live clears old results, so a same-cycle lv1 sees an empty slot
    valid_base = live_rise ? '0 : valid_q;
    cap        = live ? (lv1 & ~valid_base) : '0;
    cap_val    = live_rise ? '0 : cnt_q;
  end

  // Capture registers: clear on re-arm, latch pre-increment count
  always_comb begin
    valid_d = valid_base | cap;
    sat_d   = live_rise ? '0 : sat_q;
    delay_d = live_rise ? '0 : delay_q;
    for (int i = 0; i < NCH; i++) begin
      if (cap[i]) begin
        delay_d[i*CNT_W +: CNT_W] = cap_val;
        sat_d[i]                  = (cap_val == CMAX);
      end
    end
    all_now = &valid_d;
  end

  // Spill-state FSM next state and all-captured pulse
  always_comb begin
    state_d    = state_q;
    all_done_d = 1'b0;
    if (!live) begin
      state_d = S_IDLE;
    end else if (live_rise) begin
      state_d    = all_now ? S_DONE : S_ARMED;
      all_done_d = all_now;
    end else if (state_q == S_ARMED && all_now) begin
      state_d    = S_DONE;
      all_done_d = 1'b1;
    end
  end

  // Saturating tick counter, frozen once every channel has captured
  always_comb begin
    cnt_d = cnt_q;
    if (!live || live_rise) begin
      cnt_d = '0;
    end else if (state_q == S_ARMED && !all_now &&
                 ena_delta && cnt_q < CMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pre_live_q <= 1'b0;
      delay_q    <= '0;
      valid_q    <= '0;
      sat_q      <= '0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_live_q <= pre_live_d;
      delay_q    <= delay_d;
      valid_q    <= valid_d;
      sat_q      <= sat_d;
      all_done_q <= all_done_d;
    end
  end

  assign delay    = delay_q;
  assign valid    = valid_q;
  assign sat      = sat_q;
  assign all_done = all_done_q;
  assign state    = state_q;

`ifdef LV1_DELAY_CNT_EN
  logic [NCH-1:0]    lv1_d_q;
  logic [NCH-1:0]    lv1_rise;
  logic [NCH*16-1:0] lv1_cnt_q, lv1_cnt_d;

  // Per-channel lv1 rising-edge counters within the live window
  always_comb begin
    lv1_rise  = lv1 & ~lv1_d_q;
    lv1_cnt_d = live_rise ? '0 : lv1_cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (live && lv1_rise[i] &&
          lv1_cnt_d[i*16 +: 16] != 16'hFFFF) begin
        lv1_cnt_d[i*16 +: 16] = lv1_cnt_d[i*16 +: 16] + 16'd1;
      end
    end
  end

  // Edge-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lv1_d_q   <= '0;
      lv1_cnt_q <= '0;
    end else begin
      lv1_d_q   <= lv1;
      lv1_cnt_q <= lv1_cnt_d;
    end
  end

  assign lv1_cnt = lv1_cnt_q;
`endif

endmodule
